// File: rtl/turbo_iteration_ctrl_if.sv
// rtl/turbo_iteration_ctrl_if.sv - handshake and LLR bus bundle for the turbo iteration controller
// master = controller side, slave = surrounding chain / upstream / downstream side.
interface turbo_iteration_ctrl_if #(
  parameter int BITS            = 16,
  parameter int BITS_PER_SYMBOL = 2,
  parameter int N               = 10,
  parameter int SYMBOLS         = 10,
  parameter int ITW             = 3
);
  logic                                             start_valid;
  logic                                             start_ready;
  logic [SYMBOLS-1:0][BITS_PER_SYMBOL-1:0][BITS-1:0] enc1_in;
  logic [SYMBOLS-1:0][BITS_PER_SYMBOL-1:0][BITS-1:0] enc2_in;

  logic                                             siso_in_valid;
  logic [SYMBOLS-1:0][BITS_PER_SYMBOL-1:0][BITS-1:0] siso_enc1;
  logic [SYMBOLS-1:0][BITS_PER_SYMBOL-1:0][BITS-1:0] siso_enc2;
  logic [SYMBOLS-1:0][BITS_PER_SYMBOL-1:0][BITS-1:0] siso_extr;

  logic                                             ret_valid;
  logic [SYMBOLS-1:0][BITS_PER_SYMBOL-1:0][BITS-1:0] ret_enc1;
  logic [SYMBOLS-1:0][BITS_PER_SYMBOL-1:0][BITS-1:0] ret_enc2;
  logic [SYMBOLS-1:0][BITS_PER_SYMBOL-1:0][BITS-1:0] ret_extr;
  logic [N-1:0]                                     ret_result;

  logic                                             dec_valid;
  logic                                             dec_ready;
  logic [N-1:0]                                     dec_bits;
  logic [ITW-1:0]                                   dec_iters;
  logic                                             dec_timeout;
  logic                                             stray_ret;

  modport master (
    input  start_valid, enc1_in, enc2_in,
    input  ret_valid, ret_enc1, ret_enc2, ret_extr, ret_result,
    input  dec_ready,
    output start_ready, siso_in_valid, siso_enc1, siso_enc2, siso_extr,
    output dec_valid, dec_bits, dec_iters, dec_timeout, stray_ret
  );

  modport slave (
    output start_valid, enc1_in, enc2_in,
    output ret_valid, ret_enc1, ret_enc2, ret_extr, ret_result,
    output dec_ready,
    input  start_ready, siso_in_valid, siso_enc1, siso_enc2, siso_extr,
    input  dec_valid, dec_bits, dec_iters, dec_timeout, stray_ret
  );
endinterface

// File: rtl/turbo_iteration_ctrl.sv
// rtl/turbo_iteration_ctrl.sv - iteration controller around the two-stage SISO chain
// Early termination on stable hard decisions is compiled in only when TURBO_EARLY_TERM_EN is defined.
module turbo_iteration_ctrl #(
  parameter int BITS            = 16,
  parameter int BITS_PER_SYMBOL = 2,
  parameter int N               = 10,
  parameter int SYMBOLS         = 10,
  parameter int MAX_ITERS       = 4,
  parameter int MIN_ITERS       = 1,
  parameter int STABLE_ITERS    = 1,
  parameter int TIMEOUT         = 1023
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  turbo_iteration_ctrl_if.master bus_if
);
  localparam int ITW = $clog2(MAX_ITERS + 1);
  localparam int TW  = $clog2(TIMEOUT + 1);
  localparam logic [ITW-1:0] MAX_IT = ITW'(MAX_ITERS);
  localparam logic [TW-1:0]  TMO    = TW'(TIMEOUT);

  typedef logic [SYMBOLS-1:0][BITS_PER_SYMBOL-1:0][BITS-1:0] llr_blk_t;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_OUTPUT} state_t;

  state_t         state_q, state_d;
  llr_blk_t       enc1_q, enc1_d;
  llr_blk_t       enc2_q, enc2_d;
  llr_blk_t       extr_q, extr_d;
  logic [ITW-1:0] iter_q, iter_d;
  logic [TW-1:0]  wcnt_q, wcnt_d;
  logic [N-1:0]   bits_q, bits_d;
  logic [ITW-1:0] iters_q, iters_d;
  logic           tmo_q, tmo_d;
  logic           stray_q, stray_d;
  logic           done;
  logic [N-1:0]   timeout_bits;

`ifdef TURBO_EARLY_TERM_EN
  localparam int SW = $clog2(STABLE_ITERS + 1);
  localparam logic [SW-1:0]  STABLE_MAX = SW'(STABLE_ITERS);
  localparam logic [ITW-1:0] MIN_IT     = ITW'(MIN_ITERS);

  logic [N-1:0]  prev_q, prev_d;
  logic          prev_vld_q, prev_vld_d;
  logic [SW-1:0] stable_q, stable_d;

  // An aborted block still reports the last decisions the chain produced.
  assign timeout_bits = prev_q;
`else
  assign timeout_bits = '0;
`endif

  always_comb begin
    state_d = state_q;
    enc1_d  = enc1_q;
    enc2_d  = enc2_q;
    extr_d  = extr_q;
    iter_d  = iter_q;
    wcnt_d  = wcnt_q;
    bits_d  = bits_q;
    iters_d = iters_q;
    tmo_d   = tmo_q;
    stray_d = bus_if.ret_valid && (state_q != S_WAIT);
    done    = 1'b0;
`ifdef TURBO_EARLY_TERM_EN
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
    stable_d   = stable_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus_if.start_valid) begin
          enc1_d  = bus_if.enc1_in;
          enc2_d  = bus_if.enc2_in;
          extr_d  = '0;
          iter_d  = '0;
`ifdef TURBO_EARLY_TERM_EN
          prev_d     = '0;
          prev_vld_d = 1'b0;
          stable_d   = '0;
`endif
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
        wcnt_d  = '0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (bus_if.ret_valid) begin
          enc1_d = bus_if.ret_enc1;
          enc2_d = bus_if.ret_enc2;
          extr_d = bus_if.ret_extr;
          iter_d = iter_q + 1'b1;
`ifdef TURBO_EARLY_TERM_EN
          if (prev_vld_q && (bus_if.ret_result == prev_q)) begin
            stable_d = (stable_q == STABLE_MAX) ? stable_q : stable_q + 1'b1;
          end else begin
            stable_d = '0;
          end
          prev_d     = bus_if.ret_result;
          prev_vld_d = 1'b1;
          done = (iter_d == MAX_IT) || ((iter_d >= MIN_IT) && (stable_d >= STABLE_MAX));
`else
          done = (iter_d == MAX_IT);
`endif
          if (done) begin
            bits_d  = bus_if.ret_result;
            iters_d = iter_d;
            tmo_d   = 1'b0;
            state_d = S_OUTPUT;
          end else begin
            state_d = S_ISSUE;
          end
        end else if (wcnt_q == TMO) begin
          bits_d  = timeout_bits;
          iters_d = iter_q;
          tmo_d   = 1'b1;
          state_d = S_OUTPUT;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end

      S_OUTPUT: begin
        if (bus_if.dec_ready) begin
          bits_d  = '0;
          iters_d = '0;
          tmo_d   = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      enc1_q  <= '0;
      enc2_q  <= '0;
      extr_q  <= '0;
      iter_q  <= '0;
      wcnt_q  <= '0;
      bits_q  <= '0;
      iters_q <= '0;
      tmo_q   <= 1'b0;
      stray_q <= 1'b0;
    end else begin
      state_q <= state_d;
      enc1_q  <= enc1_d;
      enc2_q  <= enc2_d;
      extr_q  <= extr_d;
      iter_q  <= iter_d;
      wcnt_q  <= wcnt_d;
      bits_q  <= bits_d;
      iters_q <= iters_d;
      tmo_q   <= tmo_d;
      stray_q <= stray_d;
    end
  end

`ifdef TURBO_EARLY_TERM_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      stable_q   <= '0;
    end else begin
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
      stable_q   <= stable_d;
    end
  end
`endif

  assign bus_if.start_ready   = (state_q == S_IDLE);
  assign bus_if.siso_in_valid = (state_q == S_ISSUE);
  assign bus_if.siso_enc1     = enc1_q;
  assign bus_if.siso_enc2     = enc2_q;
  assign bus_if.siso_extr     = extr_q;
  assign bus_if.dec_valid     = (state_q == S_OUTPUT);
  assign bus_if.dec_bits      = bits_q;
  assign bus_if.dec_iters     = iters_q;
  assign bus_if.dec_timeout   = tmo_q;
  assign bus_if.stray_ret     = stray_q;

endmodule

// File: tb/tb_turbo_iteration_ctrl.sv
// tb/tb_turbo_iteration_ctrl.sv - directed and randomized bench for turbo_iteration_ctrl
// Expectations for the early-stop rule follow TURBO_EARLY_TERM_EN as the DUT does.
module tb_turbo_iteration_ctrl;
  localparam int BITS         = 16;
  localparam int BPS          = 2;
  localparam int N            = 10;
  localparam int SYMBOLS      = 10;
  localparam int MAX_ITERS    = 4;
  localparam int MIN_ITERS    = 1;
  localparam int STABLE_ITERS = 1;
  localparam int TIMEOUT      = 1023;
  localparam int ITW          = $clog2(MAX_ITERS + 1);

  typedef logic [SYMBOLS-1:0][BPS-1:0][BITS-1:0] llr_t;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   stray_cnt = 0;
  logic [N-1:0]   dec_list [MAX_ITERS];
  logic [N-1:0]   obs_bits;
  logic [ITW-1:0] obs_iters;

  always #5 clk = ~clk;

  turbo_iteration_ctrl_if #(
    .BITS(BITS), .BITS_PER_SYMBOL(BPS), .N(N), .SYMBOLS(SYMBOLS), .ITW(ITW)
  ) bus ();

  turbo_iteration_ctrl #(
    .BITS(BITS), .BITS_PER_SYMBOL(BPS), .N(N), .SYMBOLS(SYMBOLS),
    .MAX_ITERS(MAX_ITERS), .MIN_ITERS(MIN_ITERS), .STABLE_ITERS(STABLE_ITERS),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus_if(bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.stray_ret === 1'b1) stray_cnt++;
  endtask

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic llr_t rand_llr();
    llr_t v;
    for (int s = 0; s < SYMBOLS; s++)
      for (int b = 0; b < BPS; b++)
        v[s][b] = BITS'($urandom);
    return v;
  endfunction

  // Iterations used: MAX_ITERS, or earlier once the trailing run of identical decisions is long enough.
  function automatic int model_iters();
    for (int k = 1; k <= MAX_ITERS; k++) begin
      if (k == MAX_ITERS) return k;
`ifdef TURBO_EARLY_TERM_EN
      if (k >= MIN_ITERS) begin
        int run;
        run = 0;
        for (int j = k; j >= 2; j--) begin
          if (dec_list[j-1] != dec_list[j-2]) break;
          run++;
        end
        if (run >= STABLE_ITERS) return k;
      end
`endif
    end
    return MAX_ITERS;
  endfunction

  task automatic run_block(input int lat, input bit no_ret, input int hold);
    llr_t e1, e2, ex;
    int n, exp_it, n_issue;
    logic [N-1:0] exp_bits;
    e1 = rand_llr();
    e2 = rand_llr();
    ex = '0;
    n = 0;
    while (bus.start_ready !== 1'b1 && n < 50) begin tick(); n++; end
    check("start_ready", 512'(bus.start_ready), 512'(1'b1));
    bus.enc1_in = e1;
    bus.enc2_in = e2;
    bus.start_valid = 1'b1;
    tick();
    bus.start_valid = 1'b0;
    bus.enc1_in = rand_llr();
    bus.enc2_in = rand_llr();
    if (no_ret) begin
      exp_it = 0;
      exp_bits = '0;
    end else begin
      exp_it = model_iters();
      exp_bits = dec_list[exp_it-1];
    end
    n_issue = no_ret ? 1 : exp_it;
    for (int it = 0; it < n_issue; it++) begin
      n = 0;
      while (bus.siso_in_valid !== 1'b1 && n < 8) begin tick(); n++; end
      check("issue_pulse", 512'(bus.siso_in_valid), 512'(1'b1));
      check("siso_enc1", 512'(bus.siso_enc1), 512'(e1));
      check("siso_enc2", 512'(bus.siso_enc2), 512'(e2));
      check("siso_extr", 512'(bus.siso_extr), 512'(ex));
      tick();
      check("issue_one_cycle", 512'(bus.siso_in_valid), 512'(1'b0));
      if (!no_ret) begin
        repeat (lat - 1) tick();
        e1 = rand_llr();
        e2 = rand_llr();
        ex = rand_llr();
        bus.ret_enc1 = e1;
        bus.ret_enc2 = e2;
        bus.ret_extr = ex;
        bus.ret_result = dec_list[it];
        bus.ret_valid = 1'b1;
        tick();
        bus.ret_valid = 1'b0;
        bus.ret_extr = rand_llr();
        bus.ret_result = N'($urandom);
      end
    end
    n = 0;
    while (bus.dec_valid !== 1'b1 && n < TIMEOUT + 50) begin tick(); n++; end
    check("dec_valid", 512'(bus.dec_valid), 512'(1'b1));
    if (no_ret) check("timeout_latency", 512'(n), 512'(TIMEOUT + 1));
    check("dec_bits", 512'(bus.dec_bits), 512'(exp_bits));
    check("dec_iters", 512'(bus.dec_iters), 512'(exp_it));
    check("dec_timeout", 512'(bus.dec_timeout), 512'(no_ret));
    obs_bits = bus.dec_bits;
    obs_iters = bus.dec_iters;
    bus.start_valid = (hold > 0);
    for (int h = 0; h < hold; h++) begin
      tick();
      check("hold_valid", 512'(bus.dec_valid), 512'(1'b1));
      check("hold_bits", 512'(bus.dec_bits), 512'(exp_bits));
      check("hold_iters", 512'(bus.dec_iters), 512'(exp_it));
      check("hold_start_ready", 512'(bus.start_ready), 512'(1'b0));
      check("hold_no_issue", 512'(bus.siso_in_valid), 512'(1'b0));
    end
    bus.start_valid = 1'b0;
    bus.dec_ready = 1'b1;
    tick();
    bus.dec_ready = 1'b0;
    check("release_valid", 512'(bus.dec_valid), 512'(1'b0));
    check("release_bits", 512'(bus.dec_bits), 512'(0));
    check("release_iters", 512'(bus.dec_iters), 512'(0));
    check("release_timeout", 512'(bus.dec_timeout), 512'(1'b0));
    check("release_start_ready", 512'(bus.start_ready), 512'(1'b1));
  endtask

  initial begin
    int s0, n;
    logic [N-1:0] base;
    rst = 1'b1;
    bus.start_valid = 1'b0;
    bus.enc1_in = '0;
    bus.enc2_in = '0;
    bus.ret_valid = 1'b0;
    bus.ret_enc1 = '0;
    bus.ret_enc2 = '0;
    bus.ret_extr = '0;
    bus.ret_result = '0;
    bus.dec_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    check("rst_start_ready", 512'(bus.start_ready), 512'(1'b1));
    check("rst_issue", 512'(bus.siso_in_valid), 512'(1'b0));
    check("rst_dec_valid", 512'(bus.dec_valid), 512'(1'b0));
    check("rst_dec_bits", 512'(bus.dec_bits), 512'(0));
    check("rst_siso_extr", 512'(bus.siso_extr), 512'(0));
    check("rst_stray", 512'(bus.stray_ret), 512'(1'b0));

    // Constant decisions every iteration.
    for (int i = 0; i < MAX_ITERS; i++) dec_list[i] = 10'h2A5;
    run_block(40, 1'b0, 0);
    check("const_bits", 512'(obs_bits), 512'(10'h2A5));
`ifdef TURBO_EARLY_TERM_EN
    check("const_iters", 512'(obs_iters), 512'(2));
`else
    check("const_iters", 512'(obs_iters), 512'(4));
`endif

    // Changing decisions run to MAX_ITERS.
    for (int i = 0; i < MAX_ITERS; i++) dec_list[i] = N'(i + 1);
    run_block(40, 1'b0, 0);
    check("changing_bits", 512'(obs_bits), 512'(10'h004));
    check("changing_iters", 512'(obs_iters), 512'(4));

    // Chain never returns; downstream stalls for 20 cycles.
    run_block(1, 1'b1, 20);

    // Return arriving on the timeout cycle is a normal capture.
    for (int i = 0; i < MAX_ITERS; i++) dec_list[i] = N'(i + 7);
    run_block(TIMEOUT + 1, 1'b0, 1);

    // Stray return while idle.
    s0 = stray_cnt;
    bus.ret_valid = 1'b1;
    tick();
    bus.ret_valid = 1'b0;
    check("stray_no_issue", 512'(bus.siso_in_valid), 512'(1'b0));
    tick();
    tick();
    check("stray_pulse_count", 512'(stray_cnt - s0), 512'(1));
    check("stray_still_idle", 512'(bus.start_ready), 512'(1'b1));

    // Reset while waiting on the chain.
    bus.enc1_in = rand_llr();
    bus.start_valid = 1'b1;
    tick();
    bus.start_valid = 1'b0;
    repeat (6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_idle", 512'(bus.start_ready), 512'(1'b1));
    check("midrst_dec_valid", 512'(bus.dec_valid), 512'(1'b0));
    check("midrst_siso_enc1", 512'(bus.siso_enc1), 512'(0));
    check("midrst_siso_extr", 512'(bus.siso_extr), 512'(0));
    s0 = stray_cnt;
    bus.ret_valid = 1'b1;
    tick();
    bus.ret_valid = 1'b0;
    tick();
    check("midrst_stray", 512'(stray_cnt - s0), 512'(1));
    for (int i = 0; i < MAX_ITERS; i++) dec_list[i] = N'($urandom);
    run_block(5, 1'b0, 2);

    // Randomized blocks: decisions drawn from a small set so repeats occur.
    s0 = stray_cnt;
    for (int b = 0; b < 20; b++) begin
      base = N'($urandom);
      for (int i = 0; i < MAX_ITERS; i++)
        dec_list[i] = ($urandom_range(0, 2) != 0) ? base : N'($urandom);
      n = $urandom_range(1, 3);
      run_block(int'($urandom_range(1, 60)), 1'b0, n);
    end
    check("random_no_stray", 512'(stray_cnt - s0), 512'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
